// File: rtl/spi_master_ctrl_pkg.sv
// Shared types for the SPI master: FSM state encoding and SPI mode constants.
package spi_master_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER,
      ST_HOLD
   } spi_state_t;

   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_master_ctrl_clk_div.sv
// Half-period divider for sclk: emits a one-cycle tick every CLK_DIV enabled cycles.
module spi_master_ctrl_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic i_mclk,
   input  logic i_reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] r_div_cnt;

   assign o_tick = i_en && (r_div_cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge i_mclk) begin
      if (i_reset || i_clr) begin
         r_div_cnt <= '0;
      end else if (i_en) begin
         if (o_tick) r_div_cnt <= '0;
         else        r_div_cnt <= r_div_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master engine: byte load, full-duplex MSB-first transfer, received byte readout.
// state   | meaning
// ST_IDLE | ss_n high, sclk low, waiting for start
// ST_XFER | shifting DATA_W bits, sclk toggles on every tick
// ST_HOLD | ss_n still low for one half-period after the last falling edge
import spi_master_ctrl_pkg::*;

module spi_master_ctrl #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 2
) (
   input  logic              mclk,
   input  logic              reset,
   input  logic              load_master,
   input  logic              start,
   input  logic              read_master,
   input  logic [DATA_W-1:0] data_in_master,
   output logic [DATA_W-1:0] data_out_master,
   output logic              busy,
   output logic              done,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              ss_n
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   spi_state_t        r_state;
   logic [DATA_W-1:0] r_tx_buf;
   logic [DATA_W-1:0] r_rx_buf;
   logic [DATA_W-1:0] r_tx_shift;
   logic [DATA_W-1:0] r_rx_shift;
   logic [DATA_W-1:0] r_dout;
   logic [BW-1:0]     r_bit_cnt;
   logic              r_ss_n;
   logic              r_sclk;
   logic              r_busy;
   logic              r_done;
   logic              w_tick;
   logic              w_accept;

   assign w_accept = (r_state == ST_IDLE) && start;

   spi_master_ctrl_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .i_mclk  (mclk),
      .i_reset (reset),
      .i_en    (r_state != ST_IDLE),
      .i_clr   (w_accept),
      .o_tick  (w_tick)
   );

   always_ff @(posedge mclk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_tx_buf   <= '0;
         r_rx_buf   <= '0;
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_dout     <= '0;
         r_bit_cnt  <= '0;
         r_ss_n     <= 1'b1;
         r_sclk     <= SPI_CPOL;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (load_master) r_tx_buf <= data_in_master;
         if (read_master) r_dout <= r_rx_buf;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_tx_shift <= load_master ? data_in_master : r_tx_buf;
                  r_ss_n     <= 1'b0;
                  r_busy     <= 1'b1;
                  r_bit_cnt  <= '0;
                  r_state    <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (w_tick) begin
                  if (!r_sclk) begin
                     r_sclk     <= 1'b1;
                     r_rx_shift <= {r_rx_shift[DATA_W-2:0], miso};
                  end else begin
                     r_sclk <= 1'b0;
                     // tx_shift is left untouched after the last bit so mosi stays stable through HOLD
                     if (r_bit_cnt == BW'(DATA_W - 1)) begin
                        r_state <= ST_HOLD;
                     end else begin
                        r_tx_shift <= r_tx_shift << 1;
                        r_bit_cnt  <= r_bit_cnt + BW'(1);
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (w_tick) begin
                  r_rx_buf <= r_rx_shift;
                  r_done   <= 1'b1;
                  r_ss_n   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign data_out_master = r_dout;
   assign busy            = r_busy;
   assign done            = r_done;
   assign sclk            = r_sclk;
   assign ss_n            = r_ss_n;
   assign mosi            = ~r_ss_n & r_tx_shift[DATA_W-1];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: timeline-based reference model checked every cycle, directed scenarios, random traffic.
module tb_spi_master_ctrl;

   localparam int DATA_W  = 8;
   localparam int CLK_DIV = 2;
   localparam int T_DONE  = (2 * DATA_W + 1) * CLK_DIV;
   localparam int T_SHIFT = 2 * DATA_W * CLK_DIV;

   logic       mclk = 1'b0;
   logic       reset = 1'b1;
   logic       load_master = 1'b0;
   logic       start = 1'b0;
   logic       read_master = 1'b0;
   logic [7:0] data_in_master = 8'h00;
   logic [7:0] data_out_master;
   logic       busy, done, sclk, mosi, miso, ss_n;

   int         mode = 0;
   logic       r_rand = 1'b0;
   logic [7:0] slave_data = 8'h00, slave_tx = 8'h00, slave_rx = 8'h00, mosi_seen = 8'h00;

   int         n_cmp = 0, n_err = 0, n_done = 0;
   bit         chk_en = 1'b0;

   bit         m_active = 1'b0, m_done = 1'b0;
   int         m_k = 0;
   logic [7:0] m_tx_buf = 8'h00, m_rx_buf = 8'h00, m_dout = 8'h00, m_tx_data = 8'h00, m_rx_bits = 8'h00;

   logic [12:0] exp_v, act_v;
   int          h_idx, b_idx;

   spi_master_ctrl #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
      .mclk            (mclk),
      .reset           (reset),
      .load_master     (load_master),
      .start           (start),
      .read_master     (read_master),
      .data_in_master  (data_in_master),
      .data_out_master (data_out_master),
      .busy            (busy),
      .done            (done),
      .sclk            (sclk),
      .mosi            (mosi),
      .miso            (miso),
      .ss_n            (ss_n)
   );

   always #5 mclk = ~mclk;

   assign miso = (mode == 1) ? mosi : (mode == 2) ? (~ss_n & slave_tx[7]) : r_rand;

   // simple mode-0 slave and an observer of mosi at each sclk rise
   always @(negedge ss_n) slave_tx = slave_data;
   always @(posedge sclk) begin
      slave_rx  = {slave_rx[6:0], mosi};
      mosi_seen = {mosi_seen[6:0], mosi};
   end
   always @(negedge sclk) slave_tx = slave_tx << 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   // reference model: a transfer is a timeline of k cycles since the accepting edge
   always @(posedge mclk) begin
      if (reset) begin
         m_active = 1'b0; m_done = 1'b0; m_k = 0;
         m_tx_buf = 8'h00; m_rx_buf = 8'h00; m_dout = 8'h00;
      end else begin
         m_done = 1'b0;
         if (read_master) m_dout = m_rx_buf;
         if (m_active) begin
            m_k++;
            if ((m_k % CLK_DIV == 0) && ((m_k / CLK_DIV) % 2 == 1) && (m_k < T_SHIFT))
               m_rx_bits = {m_rx_bits[6:0], miso};
            if (m_k == T_DONE) begin
               m_active = 1'b0;
               m_done   = 1'b1;
               m_rx_buf = m_rx_bits;
            end
         end else if (start) begin
            m_active  = 1'b1;
            m_k       = 0;
            m_tx_data = load_master ? data_in_master : m_tx_buf;
         end
         if (load_master) m_tx_buf = data_in_master;
      end
   end

   always @(negedge mclk) begin
      if (chk_en) begin
         act_v = {ss_n, sclk, mosi, busy, done, data_out_master};
         if (m_active) begin
            h_idx = m_k / CLK_DIV;
            b_idx = h_idx / 2;
            if (b_idx > DATA_W - 1) b_idx = DATA_W - 1;
            exp_v = {1'b0, ((m_k < T_SHIFT) && (h_idx % 2 == 1)), m_tx_data[DATA_W-1-b_idx],
                     1'b1, 1'b0, m_dout};
         end else begin
            exp_v = {1'b1, 1'b0, 1'b0, 1'b0, m_done, m_dout};
         end
         check("cycle", 32'(act_v), 32'(exp_v));
         if (done) n_done++;
      end
   end

   task automatic pulse_start(input bit ld, input logic [7:0] d);
      data_in_master = d;
      load_master    = ld;
      start          = 1'b1;
      @(negedge mclk);
      start          = 1'b0;
      load_master    = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] d);
      data_in_master = d;
      load_master    = 1'b1;
      @(negedge mclk);
      load_master    = 1'b0;
   endtask

   task automatic do_read();
      read_master = 1'b1;
      @(negedge mclk);
      read_master = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         @(negedge mclk);
         lat++;
      end
      check("done_seen", 32'(done), 32'd1);
   endtask

   int lat, n0;

   initial begin
      // 1: reset
      reset = 1'b1;
      repeat (3) @(negedge mclk);
      chk_en = 1'b1;
      check("rst_ss_n", 32'(ss_n), 32'd1);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dout", 32'(data_out_master), 32'h00);
      reset = 1'b0;
      @(negedge mclk);

      // 2: loopback 0xA5
      mode = 1;
      do_load(8'hA5);
      pulse_start(1'b0, 8'h00);
      wait_done(lat);
      check("t2_latency", lat, 32'd34);
      check("t2_mosi_bits", 32'(mosi_seen), 32'hA5);
      check("t2_model_rx", 32'(m_rx_buf), 32'hA5);
      @(negedge mclk);
      do_read();
      check("t2_read", 32'(data_out_master), 32'hA5);

      // 3: slave returns 0x3C while master sends 0xC3
      mode = 2;
      slave_data = 8'h3C;
      pulse_start(1'b1, 8'hC3);
      wait_done(lat);
      check("t3_slave_rx", 32'(slave_rx), 32'hC3);
      @(negedge mclk);
      do_read();
      check("t3_read", 32'(data_out_master), 32'h3C);

      // 4: start while busy ignored, load while busy used next time
      mode = 1;
      pulse_start(1'b1, 8'h77);
      repeat (10) @(negedge mclk);
      data_in_master = 8'h11;
      load_master = 1'b1;
      start = 1'b1;
      @(negedge mclk);
      load_master = 1'b0;
      start = 1'b0;
      n0 = n_done;
      wait_done(lat);
      check("t4_latency", lat, 32'd23);
      check("t4_mosi_first", 32'(mosi_seen), 32'h77);
      repeat (40) @(negedge mclk);
      check("t4_single_done", n_done - n0, 32'd1);
      pulse_start(1'b0, 8'h00);
      wait_done(lat);
      check("t4_mosi_second", 32'(mosi_seen), 32'h11);
      @(negedge mclk);
      do_read();
      check("t4_read", 32'(data_out_master), 32'h11);

      // 5: reset during bit 3
      pulse_start(1'b1, 8'h96);
      repeat (13) @(negedge mclk);
      reset = 1'b1;
      @(negedge mclk);
      reset = 1'b0;
      check("t5_ss_n", 32'(ss_n), 32'd1);
      check("t5_sclk", 32'(sclk), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_dout", 32'(data_out_master), 32'h00);
      n0 = n_done;
      repeat (60) @(negedge mclk);
      check("t5_no_done", n_done - n0, 32'd0);

      // 6: load+start same cycle overrides tx_buf
      do_load(8'hFF);
      pulse_start(1'b1, 8'h5A);
      wait_done(lat);
      check("t6_latency", lat, 32'd34);
      check("t6_mosi_bits", 32'(mosi_seen), 32'h5A);
      @(negedge mclk);
      do_read();
      check("t6_read", 32'(data_out_master), 32'h5A);

      // random traffic against the model
      mode = 0;
      for (int i = 0; i < 4000; i++) begin
         load_master    = ($urandom_range(0, 9) == 0);
         start          = ($urandom_range(0, 5) == 0);
         read_master    = ($urandom_range(0, 7) == 0);
         reset          = ($urandom_range(0, 299) == 0);
         data_in_master = 8'($urandom);
         r_rand         = 1'($urandom);
         @(negedge mclk);
      end
      load_master = 1'b0;
      start       = 1'b0;
      read_master = 1'b0;
      reset       = 1'b0;
      repeat (60) @(negedge mclk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
